// File: rtl/bb8051_sfr_bit_master.sv
// 8051 bit-operation initiator: maps a bit address to a byte and runs read-modify-write on the SFR/RAM byte bus.
// Optional macro BB8051_BIT_WRITE_SUPPRESS_EN skips the write when the modified byte equals the byte read.
module bb8051_sfr_bit_master #(
    parameter logic [7:0] BIT_RAM_BASE = 8'h20,
    parameter int         RD_LATENCY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_bit_addr,
    input  logic       carry_in,
    output logic       bus_space,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_bit,
    output logic       rsp_err,
    output logic [2:0] dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the initiator holds its payload stable while valid is 1 and ready is 0.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] idx_q, idx_d;
    logic       carry_q, carry_d;
    logic [7:0] addr_q, addr_d;
    logic       space_q, space_d;
    logic [7:0] wdata_q, wdata_d;
    logic       bit_q, bit_d;
    logic       err_q, err_d;
    logic [1:0] wait_q, wait_d;

    logic       capture;
    logic       rd_bit;
    logic       new_bit;
    logic [7:0] new_byte;
    logic       modifies;
    logic       do_write;

    always_comb begin
        rd_bit   = rd_data[idx_q];
        new_bit  = 1'b0;
        case (op_q)
            3'd0:    new_bit = 1'b1;
            3'd1:    new_bit = 1'b0;
            3'd2:    new_bit = ~rd_bit;
            3'd3:    new_bit = carry_q;
            default: new_bit = 1'b0;
        endcase
        new_byte         = rd_data;
        new_byte[idx_q]  = new_bit;
        modifies         = (op_q <= 3'd3) || (op_q == 3'd5);
`ifdef BB8051_BIT_WRITE_SUPPRESS_EN
        do_write         = modifies && (new_byte != rd_data);
`else
        do_write         = modifies;
`endif
        // Capture edge ends the READ cycle plus RD_LATENCY-1 WAIT cycles.
        capture = ((state_q == S_READ) && (RD_LATENCY == 1)) ||
                  ((state_q == S_WAIT) && (wait_q == 2'd0));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        addr_d  = addr_q;
        space_d = space_q;
        wdata_d = wdata_q;
        bit_d   = bit_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    idx_d   = req_bit_addr[2:0];
                    carry_d = carry_in;
                    space_d = req_bit_addr[7];
                    addr_d  = req_bit_addr[7] ? {req_bit_addr[7:3], 3'b000}
                                              : BIT_RAM_BASE + {4'b0000, req_bit_addr[6:3]};
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (RD_LATENCY != 1) begin
                    state_d = S_WAIT;
                    wait_d  = 2'(RD_LATENCY - 2);
                end
            end
            S_WAIT: begin
                if (wait_q != 2'd0) wait_d = wait_q - 2'd1;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            bit_d   = rd_bit;
            wdata_d = new_byte;
            err_d   = (op_q > 3'd5);
            state_d = do_write ? S_WRITE : S_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            idx_q   <= 3'd0;
            carry_q <= 1'b0;
            addr_q  <= 8'h00;
            space_q <= 1'b0;
            wdata_q <= 8'h00;
            bit_q   <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            addr_q  <= addr_d;
            space_q <= space_d;
            wdata_q <= wdata_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rd_en       = (state_q == S_READ);
    assign wr_en       = (state_q == S_WRITE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_bit     = rsp_valid & bit_q;
    assign rsp_err     = rsp_valid & err_q;
    assign rd_addr     = addr_q;
    assign wr_addr     = addr_q;
    assign wr_data     = wdata_q;
    assign bus_space   = space_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bb8051_sfr_bit_master.sv
// Bench for bb8051_sfr_bit_master: directed plan cases plus random bit ops against an arithmetic model.
module tb_bb8051_sfr_bit_master;

  localparam int RD_LAT = 1;

`ifdef BB8051_BIT_WRITE_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_bit_addr = 8'h00;
  logic       carry_in = 1'b0;
  logic       bus_space;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_bit;
  logic       rsp_err;
  logic [2:0] dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  bb8051_sfr_bit_master #(.BIT_RAM_BASE(8'h20), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_bit_addr(req_bit_addr), .carry_in(carry_in),
    .bus_space(bus_space), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit), .rsp_err(rsp_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_bit"}, rsp_bit, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_bus_space"}, bus_space, 0);
  endtask

  // One full bit operation; the expected sequence comes from the address map and op rules.
  task automatic do_op(input logic [2:0] op, input logic [7:0] ba, input logic cy,
                       input logic [7:0] rb, input int hold, input bit junk);
    logic [7:0] e_addr;
    logic       e_space;
    int         idx;
    logic       obit;
    logic       nbit;
    logic [7:0] nbyte;
    logic       e_wr;
    logic       e_err;
    int         e_rd_cyc, e_wr_cyc, e_rsp_cyc;
    int         nrd, nwr, nrsp;
    bit         done, fin;

    e_space = ba >= 8'd128;
    e_addr  = e_space ? 8'((ba / 8) * 8) : 8'(8'h20 + (ba % 128) / 8);
    idx     = ba % 8;
    obit    = (rb >> idx) & 8'd1;
    case (op)
      3'd0:    nbit = 1'b1;
      3'd2:    nbit = ~obit;
      3'd3:    nbit = cy;
      default: nbit = 1'b0;
    endcase
    nbyte = nbit ? (rb | (8'd1 << idx)) : (rb & ~(8'd1 << idx));
    e_err = op > 3'd5;
    e_wr  = (op != 3'd4) && !e_err && !(SUPPRESS && nbyte == rb);
    e_rd_cyc  = 1;
    e_wr_cyc  = 1 + RD_LAT;
    e_rsp_cyc = 1 + RD_LAT + (e_wr ? 1 : 0);

    @(negedge clk);
    chk("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_bit_addr = ba; carry_in = cy; rd_data = rb;
    @(posedge clk);
    #1;
    if (junk) begin
      req_op = 3'($urandom_range(0, 7)); req_bit_addr = 8'($urandom); carry_in = ~cy;
    end else begin
      req_valid = 1'b0;
    end

    nrd = 0; nwr = 0; nrsp = 0; done = 0; fin = 0;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      @(negedge clk);
      if (done) begin
        chk("ready_after_rsp", req_ready, 1);
        chk("rsp_dropped", rsp_valid, 0);
        rsp_ready = 1'b0;
        fin = 1;
      end else begin
        chk("rd_wr_excl", 32'(rd_en & wr_en), 0);
        if (rd_en) begin
          nrd++;
          chk("rd_cycle", cyc, e_rd_cyc);
          chk("rd_addr", rd_addr, e_addr);
          chk("bus_space", bus_space, e_space);
        end
        if (wr_en) begin
          nwr++;
          chk("wr_cycle", cyc, e_wr_cyc);
          chk("wr_addr", wr_addr, e_addr);
          chk("wr_data", wr_data, nbyte);
        end
        if (rsp_valid) begin
          if (nrsp == 0) chk("rsp_cycle", cyc, e_rsp_cyc);
          nrsp++;
          chk("rsp_bit", rsp_bit, obit);
          chk("rsp_err", rsp_err, e_err);
          chk("ready_busy", req_ready, 0);
          if (nrsp > hold) begin
            rsp_ready = 1'b1;
            req_valid = 1'b0;
            done = 1;
          end else begin
            rsp_ready = 1'b0;
          end
        end
      end
    end
    if (!fin) chk("op_timeout", 0, 1);
    chk("rd_count", nrd, 1);
    chk("wr_count", nwr, e_wr);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic reset_mid_write();
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_bit_addr = 8'hD5; carry_in = 1'b0; rd_data = 8'h00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd_en", rd_en, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_wr", wr_en, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_after_no_wr", wr_en, 0);
    chk_idle_outputs("rst_after");
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    reset_mid_write();

    do_op(3'd0, 8'hD5, 1'b0, 8'h00, 0, 0);
    do_op(3'd2, 8'h0B, 1'b0, 8'h08, 0, 0);
    do_op(3'd5, 8'h87, 1'b0, 8'h81, 0, 0);
    do_op(3'd5, 8'h87, 1'b0, 8'h01, 0, 0);
    do_op(3'd3, 8'hE2, 1'b1, 8'hF0, 0, 0);
    do_op(3'd4, 8'hE2, 1'b0, 8'hF0, 0, 0);
    do_op(3'd7, 8'h33, 1'b0, 8'h5A, 5, 0);
    do_op(3'd0, 8'h7F, 1'b0, 8'h80, 0, 1);
    do_op(3'd1, 8'h00, 1'b1, 8'hFF, 2, 1);

    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
            8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
